// File: rtl/gate_lut_pipe.sv
// Programmable 2-input LUT cell with a DEPTH-stage output pipeline, serial LUT load and toggle counter.
// Define GATE_LUT_PIPE_SAT_EN to make the toggle counter saturate instead of wrapping.
module gate_lut_pipe #(
  parameter int         DEPTH    = 2,
  parameter int         CNT_W    = 4,
  parameter logic [3:0] LUT_INIT = 4'b0110
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } load_state_t;

  logic clk, rst_n, a, b, load, lut_bit, mode, hold;
  assign {hold, mode, lut_bit, load, b, a, rst_n, clk} = io_in;

  load_state_t state, next_state;
  logic start_load, shift_bit, commit;
  logic [3:0] lut, shift_q;
  logic [1:0] bit_cnt;

  logic [DEPTH-1:0]  pipe, next_pipe;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0]  count;
  logic y, valid, busy, toggle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_load = 1'b0;
    shift_bit  = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          start_load = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        if (!load) begin
          next_state = IDLE;
        end else if (bit_cnt == 2'd3) begin
          commit     = 1'b1;
          next_state = DONE;
        end else begin
          shift_bit = 1'b1;
        end
      end
      DONE: begin
        if (!load) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Any LOAD edge that neither shifts nor commits is an abort, so the partial nibble is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut     <= LUT_INIT;
      shift_q <= 4'b0000;
      bit_cnt <= 2'd0;
    end else if (start_load) begin
      shift_q <= {3'b000, lut_bit};
      bit_cnt <= 2'd1;
    end else if (shift_bit) begin
      shift_q <= {shift_q[2:0], lut_bit};
      bit_cnt <= bit_cnt + 2'd1;
    end else if (commit) begin
      lut     <= {shift_q[2:0], lut_bit};
      shift_q <= 4'b0000;
      bit_cnt <= 2'd0;
    end else begin
      shift_q <= 4'b0000;
      bit_cnt <= 2'd0;
    end
  end

  always_comb begin
    next_pipe = pipe;
    for (int i = DEPTH - 1; i > 0; i--) begin
      next_pipe[i] = pipe[i-1];
    end
    next_pipe[0] = lut[{a, b}];
  end

  assign y      = pipe[DEPTH-1];
  assign toggle = next_pipe[DEPTH-1] ^ y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe  <= '0;
      fill  <= '0;
      count <= '0;
    end else if (!hold) begin
      pipe <= next_pipe;
      if (fill != FILL_MAX) fill <= fill + 1'b1;
      if (toggle) begin
`ifdef GATE_LUT_PIPE_SAT_EN
        if (count != '1) count <= count + 1'b1;
`else
        count <= count + 1'b1;
`endif
      end
    end
  end

  assign valid  = (fill == FILL_MAX);
  assign busy   = (state == LOAD);
  assign io_out = {(mode ? lut : count[3:0]), busy, valid, ~y, y};

endmodule

// File: tb/tb_gate_lut_pipe.sv
// Directed self-checking bench for gate_lut_pipe with default parameters (DEPTH=2, CNT_W=4).
module tb_gate_lut_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0, b = 1'b0, load = 1'b0, lut_bit = 1'b0, mode = 1'b0, hold = 1'b0;
  logic [7:0] io_in;
  logic [7:0] io_out;
  int tests_run = 0;
  int fail_count = 0;

  assign io_in = {hold, mode, lut_bit, load, b, a, rst_n, clk};

  gate_lut_pipe dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses reset between edges and leaves every input low.
  task automatic do_reset();
    rst_n = 1'b0;
    {a, b, load, lut_bit, mode, hold} = 6'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if (io_out !== 8'b0000_0010) begin
      fail_count++;
      $display("[TB] FAIL reset_io_out: got %b expected %b", io_out, 8'b0000_0010);
    end
    mode = 1'b1;
    #1;
    tests_run++;
    if (io_out[7:4] !== 4'b0110) begin
      fail_count++;
      $display("[TB] FAIL reset_lut_view: got %b expected %b", io_out[7:4], 4'b0110);
    end
    mode = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_xor();
    logic [1:0] ab_seq [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic       y_exp  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       v_exp  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      {a, b} = ab_seq[i];
      tick();
      tests_run++;
      if (io_out[0] !== y_exp[i] || io_out[1] !== ~y_exp[i]) begin
        fail_count++;
        $display("[TB] FAIL xor_y edge %0d: got y=%b ny=%b expected y=%b", i + 1, io_out[0], io_out[1], y_exp[i]);
      end
      tests_run++;
      if (io_out[2] !== v_exp[i]) begin
        fail_count++;
        $display("[TB] FAIL xor_valid edge %0d: got %b expected %b", i + 1, io_out[2], v_exp[i]);
      end
    end
    tests_run++;
    if (io_out[7:4] !== 4'd2) begin
      fail_count++;
      $display("[TB] FAIL xor_count: got %0d expected 2", io_out[7:4]);
    end
  endtask

  task automatic test_load_and();
    logic [3:0] bits   = 4'b1000;
    logic       busy_e [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lut_bit = bits[3-i];
      {a, b} = (i == 3) ? 2'b01 : 2'b00;
      tick();
      tests_run++;
      if (io_out[3] !== busy_e[i]) begin
        fail_count++;
        $display("[TB] FAIL load_busy edge %0d: got %b expected %b", i + 1, io_out[3], busy_e[i]);
      end
    end
    mode = 1'b1;
    #1;
    tests_run++;
    if (io_out[7:4] !== 4'b1000) begin
      fail_count++;
      $display("[TB] FAIL load_lut: got %b expected %b", io_out[7:4], 4'b1000);
    end
    // The commit edge sampled 01 through the old XOR table, so y shows 1 next.
    lut_bit = 1'b1;
    {a, b} = 2'b00;
    tick();
    tests_run++;
    if (io_out[0] !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL load_old_lut_y: got %b expected 1", io_out[0]);
    end
    tick();
    tests_run++;
    if (io_out[3] !== 1'b0 || io_out[7:4] !== 4'b1000) begin
      fail_count++;
      $display("[TB] FAIL load_done_hold: got busy=%b lut=%b expected busy=0 lut=1000", io_out[3], io_out[7:4]);
    end
    load = 1'b0;
    mode = 1'b0;
    {a, b} = 2'b11;
    tick();
    tests_run++;
    if (io_out[0] !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL and_latency: got %b expected 0", io_out[0]);
    end
    {a, b} = 2'b10;
    tick();
    tests_run++;
    if (io_out[0] !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL and_11: got %b expected 1", io_out[0]);
    end
    {a, b} = 2'b01;
    tick();
    tests_run++;
    if (io_out[0] !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL and_10: got %b expected 0", io_out[0]);
    end
    {a, b} = 2'b00;
    tick();
    tests_run++;
    if (io_out[0] !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL and_01: got %b expected 0", io_out[0]);
    end
  endtask

  task automatic test_abort();
    do_reset();
    load = 1'b1;
    lut_bit = 1'b1;
    tick();
    tick();
    tests_run++;
    if (io_out[3] !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL abort_busy_mid: got %b expected 1", io_out[3]);
    end
    load = 1'b0;
    mode = 1'b1;
    tick();
    tests_run++;
    if (io_out[3] !== 1'b0 || io_out[7:4] !== 4'b0110) begin
      fail_count++;
      $display("[TB] FAIL abort_idle: got busy=%b lut=%b expected busy=0 lut=0110", io_out[3], io_out[7:4]);
    end
    // A fresh load 1111 that is reset part-way must restore the XOR table.
    load = 1'b1;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (io_out[3] !== 1'b0 || io_out[7:4] !== 4'b0110) begin
      fail_count++;
      $display("[TB] FAIL reset_mid_load: got busy=%b lut=%b expected busy=0 lut=0110", io_out[3], io_out[7:4]);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    tests_run++;
    if (io_out[7:4] !== 4'b1111) begin
      fail_count++;
      $display("[TB] FAIL reload_after_reset: got %b expected 1111", io_out[7:4]);
    end
    load = 1'b0;
    mode = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    hold = 1'b0;
    tick();
    tests_run++;
    if (io_out[2] !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL hold_valid_first: got %b expected 0", io_out[2]);
    end
    {a, b} = 2'b01;
    tick();
    tests_run++;
    if (io_out[2] !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL hold_valid_second: got %b expected 1", io_out[2]);
    end
    tick();
    tests_run++;
    if (io_out[0] !== 1'b1 || io_out[7:4] !== 4'd1) begin
      fail_count++;
      $display("[TB] FAIL hold_pre: got y=%b count=%0d expected y=1 count=1", io_out[0], io_out[7:4]);
    end
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      {a, b} = 2'(i);
      tick();
      tests_run++;
      if (io_out[2:0] !== 3'b101 || io_out[7:4] !== 4'd1) begin
        fail_count++;
        $display("[TB] FAIL hold_frozen edge %0d: got %b expected y=1 valid=1 count=1", i + 1, io_out);
      end
    end
    hold = 1'b0;
    {a, b} = 2'b00;
    tick();
    tests_run++;
    if (io_out[0] !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL hold_resume_latency: got %b expected 1", io_out[0]);
    end
    tick();
    tests_run++;
    if (io_out[0] !== 1'b0 || io_out[7:4] !== 4'd2) begin
      fail_count++;
      $display("[TB] FAIL hold_resume: got y=%b count=%0d expected y=0 count=2", io_out[0], io_out[7:4]);
    end
  endtask

  task automatic test_counter();
    logic [3:0] exp16, exp17, exp19;
`ifdef GATE_LUT_PIPE_SAT_EN
    exp16 = 4'd15; exp17 = 4'd15; exp19 = 4'd15;
`else
    exp16 = 4'd15; exp17 = 4'd0;  exp19 = 4'd2;
`endif
    do_reset();
    for (int n = 1; n <= 19; n++) begin
      {a, b} = (n % 2 == 1) ? 2'b01 : 2'b00;
      tick();
      if (n == 16) begin
        tests_run++;
        if (io_out[7:4] !== exp16) begin
          fail_count++;
          $display("[TB] FAIL count_15_toggles: got %0d expected %0d", io_out[7:4], exp16);
        end
      end else if (n == 17) begin
        tests_run++;
        if (io_out[7:4] !== exp17) begin
          fail_count++;
          $display("[TB] FAIL count_16_toggles: got %0d expected %0d", io_out[7:4], exp17);
        end
      end else if (n == 19) begin
        tests_run++;
        if (io_out[7:4] !== exp19) begin
          fail_count++;
          $display("[TB] FAIL count_18_toggles: got %0d expected %0d", io_out[7:4], exp19);
        end
      end
    end
    mode = 1'b1;
    #1;
    tests_run++;
    if (io_out[7:4] !== 4'b0110) begin
      fail_count++;
      $display("[TB] FAIL mode_comb: got %b expected 0110", io_out[7:4]);
    end
    mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_xor();
    test_load_and();
    test_abort();
    test_hold();
    test_counter();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
